// File: rtl/uart_transceiver.sv
// uart_transceiver
// Full-duplex 8N1 UART (1 start bit, 8 data bits LSB-first, 1 stop bit,
// no parity). A shared clock-enable tick runs at BAUD_RATE*PRESCALER and
// drives both the receiver and the transmitter. The receiver oversamples
// rx and takes its decision at the centre of each bit.
//
// Parameters:
//   CLOCK_RATE  system clock frequency in Hz
//   BAUD_RATE   serial bit rate
//   PRESCALER   oversample ticks per bit (even, >= 4)
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   rx              serial input, idle high, asynchronous to clk
//   tx              serial output, idle high
//   transmit        level request to send tx_byte
//   tx_byte         byte to send, captured when a frame starts
//   received        one-cycle pulse, rx_byte holds a new good byte
//   rx_byte         last good received byte
//   is_receiving    receiver is not idle
//   is_transmitting a frame is on tx (start through end of stop)
//   rx_error        one-cycle pulse on a framing error (stop bit low)
module uart_transceiver #(
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PRESCALER  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting,
    output logic       rx_error
);

    localparam int CLOCK_DIVIDE = CLOCK_RATE / (BAUD_RATE * PRESCALER);
    localparam int DIV_W        = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam int CNT_W        = $clog2(PRESCALER + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [CNT_W-1:0] TICKS_BIT  = CNT_W'(PRESCALER);
    localparam logic [CNT_W-1:0] TICKS_HALF = CNT_W'(PRESCALER / 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             rx_meta;
    logic             rx_sync;

    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_idx, rx_idx_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic [7:0]       rx_byte_n;
    logic             received_n;
    logic             rx_error_n;

    tx_state_t        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_idx, tx_idx_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_n;

    // Free-running divider; with CLOCK_DIVIDE == 1 the tick is always high.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // Two-flop synchroniser; resets to the idle line level so no false
    // start bit is seen coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            received <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_byte  <= rx_byte_n;
            received <= received_n;
            rx_error <= rx_error_n;
        end
    end

    // Receiver next state. The counter holds ticks remaining until the next
    // decision point; loading half a bit first puts later samples at bit
    // centres. Leaving at stop-bit centre allows back-to-back frames.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_byte_n  = rx_byte;
        received_n = 1'b0;
        rx_error_n = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = TICKS_HALF;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_cnt == CNT_ONE) begin
                        if (!rx_sync) begin
                            rx_state_n = RX_DATA;
                            rx_idx_n   = 3'd0;
                            rx_cnt_n   = TICKS_BIT;
                        end else begin
                            rx_state_n = RX_IDLE;
                        end
                    end else begin
                        rx_cnt_n = rx_cnt - CNT_ONE;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_cnt == CNT_ONE) begin
                        rx_shift_n = {rx_sync, rx_shift[7:1]};
                        rx_cnt_n   = TICKS_BIT;
                        if (rx_idx == 3'd7) begin
                            rx_state_n = RX_STOP;
                        end else begin
                            rx_idx_n = rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt_n = rx_cnt - CNT_ONE;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_cnt == CNT_ONE) begin
                        rx_state_n = RX_IDLE;
                        if (rx_sync) begin
                            rx_byte_n  = rx_shift;
                            received_n = 1'b1;
                        end else begin
                            rx_error_n = 1'b1;
                        end
                    end else begin
                        rx_cnt_n = rx_cnt - CNT_ONE;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    assign is_receiving = (rx_state != RX_IDLE);

    // Transmitter state and datapath registers; tx is registered so the
    // line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
        end
    end

    // Transmitter next state. The byte is captured at frame start so later
    // tx_byte changes cannot corrupt the frame; transmit is only looked at
    // in idle, so a held request chains frames back-to-back.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_n       = tx;
        case (tx_state)
            TX_IDLE: begin
                tx_n = 1'b1;
                if (transmit) begin
                    tx_state_n = TX_START;
                    tx_shift_n = tx_byte;
                    tx_cnt_n   = TICKS_BIT;
                    tx_n       = 1'b0;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_cnt == CNT_ONE) begin
                        tx_state_n = TX_DATA;
                        tx_idx_n   = 3'd0;
                        tx_cnt_n   = TICKS_BIT;
                        tx_n       = tx_shift[0];
                    end else begin
                        tx_cnt_n = tx_cnt - CNT_ONE;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_cnt == CNT_ONE) begin
                        tx_cnt_n = TICKS_BIT;
                        if (tx_idx == 3'd7) begin
                            tx_state_n = TX_STOP;
                            tx_n       = 1'b1;
                        end else begin
                            tx_idx_n   = tx_idx + 3'd1;
                            tx_shift_n = {1'b0, tx_shift[7:1]};
                            tx_n       = tx_shift[1];
                        end
                    end else begin
                        tx_cnt_n = tx_cnt - CNT_ONE;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_cnt == CNT_ONE) begin
                        tx_state_n = TX_IDLE;
                    end else begin
                        tx_cnt_n = tx_cnt - CNT_ONE;
                    end
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                tx_n       = 1'b1;
            end
        endcase
    end

    assign is_transmitting = (tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver
// Directed bench for uart_transceiver. Parameters are scaled so that the
// clock divider is 2 and one bit period is 16 clocks, keeping frames short.
module tb_uart_transceiver;

    localparam int CLK_RATE = 153600;
    localparam int BAUD     = 9600;
    localparam int PRESC    = 8;
    localparam int BIT_CLKS = PRESC * (CLK_RATE / (BAUD * PRESC));

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       tx;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_receiving;
    logic       is_transmitting;
    logic       rx_error;

    int tests_run = 0;
    int failures  = 0;

    int   recv_cycles     = 0;
    int   err_cycles      = 0;
    int   rx_busy_cycles  = 0;
    int   tx_frames       = 0;
    int   idle_violations = 0;
    logic prev_tx_busy    = 1'b0;

    int r0, e0, b0, f0, v0;

    uart_transceiver #(
        .CLOCK_RATE(CLK_RATE),
        .BAUD_RATE (BAUD),
        .PRESCALER (PRESC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx             (rx),
        .tx             (tx),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .received       (received),
        .rx_byte        (rx_byte),
        .is_receiving   (is_receiving),
        .is_transmitting(is_transmitting),
        .rx_error       (rx_error)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (received === 1'b1) recv_cycles <= recv_cycles + 1;
        if (rx_error === 1'b1) err_cycles <= err_cycles + 1;
        if (is_receiving === 1'b1) rx_busy_cycles <= rx_busy_cycles + 1;
        if (is_transmitting === 1'b1 && prev_tx_busy !== 1'b1) tx_frames <= tx_frames + 1;
        prev_tx_busy <= is_transmitting;
        if (tx !== 1'b1 || received !== 1'b0 || rx_error !== 1'b0 ||
            is_receiving !== 1'b0 || is_transmitting !== 1'b0)
            idle_violations <= idle_violations + 1;
    end

    // Hard stop in case something hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one serial frame on rx. The stop level is held for 12 clocks
    // before returning high, so a low stop bit is released before the
    // receiver's re-triggered start check and cannot spawn a phantom frame.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop_bit;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Follows one tx frame from its falling start edge, sampling each bit
    // mid-period and checking that is_transmitting drops after the stop bit.
    task automatic checkTxFrame(input string tag, input logic [7:0] data);
        int waited = 0;
        @(posedge clk);
        #1;
        while (tx !== 1'b0 && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput($sformatf("%s_start_edge", tag), 32'(tx), 32'(0));
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        checkOutput($sformatf("%s_start_bit", tag), 32'(tx), 32'(0));
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLKS) @(posedge clk);
            #1;
            checkOutput($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(data[i]));
        end
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        checkOutput($sformatf("%s_stop_bit", tag), 32'(tx), 32'(1));
        repeat (5) @(posedge clk);
        #1;
        checkOutput($sformatf("%s_busy_late", tag), 32'(is_transmitting), 32'(1));
        repeat (4) @(posedge clk);
        #1;
        checkOutput($sformatf("%s_busy_end", tag), 32'(is_transmitting), 32'(0));
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        transmit = 1'b0;
        tx_byte  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset and long idle window.
        v0 = idle_violations;
        repeat (10000) @(negedge clk);
        #1;
        checkOutput("reset_idle_window", 32'(idle_violations - v0), 32'(0));
        checkOutput("reset_tx", 32'(tx), 32'(1));
        checkOutput("reset_rx_byte", 32'(rx_byte), 32'(0));

        // Receive 0xF0.
        r0 = recv_cycles; e0 = err_cycles; b0 = rx_busy_cycles;
        applyStimulus(8'hF0, 1'b1);
        #1;
        checkOutput("rxF0_busy_seen", 32'((rx_busy_cycles - b0) > 100), 32'(1));
        checkOutput("rxF0_received_cycles", 32'(recv_cycles - r0), 32'(1));
        checkOutput("rxF0_rx_byte", 32'(rx_byte), 32'(8'hF0));
        checkOutput("rxF0_no_error", 32'(err_cycles - e0), 32'(0));
        checkOutput("rxF0_idle_after", 32'(is_receiving), 32'(0));

        // Transmit 0x01; request held two bit periods, tx_byte changed mid-frame.
        f0 = tx_frames;
        tx_byte  = 8'h01;
        transmit = 1'b1;
        fork
            checkTxFrame("tx01", 8'h01);
            begin
                repeat (BIT_CLKS) @(negedge clk);
                tx_byte = 8'hFF;
                repeat (BIT_CLKS) @(negedge clk);
                transmit = 1'b0;
            end
        join
        repeat (3 * BIT_CLKS) @(negedge clk);
        #1;
        checkOutput("tx01_one_frame", 32'(tx_frames - f0), 32'(1));
        checkOutput("tx01_idle_tx", 32'(tx), 32'(1));

        // Framing error on 0x55.
        r0 = recv_cycles; e0 = err_cycles;
        @(negedge clk);
        applyStimulus(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("ferr_error_cycles", 32'(err_cycles - e0), 32'(1));
        checkOutput("ferr_no_received", 32'(recv_cycles - r0), 32'(0));
        checkOutput("ferr_rx_byte_kept", 32'(rx_byte), 32'(8'hF0));
        checkOutput("ferr_idle_after", 32'(is_receiving), 32'(0));

        // Glitch shorter than half a bit.
        r0 = recv_cycles; e0 = err_cycles; b0 = rx_busy_cycles;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        checkOutput("glitch_busy_seen", 32'((rx_busy_cycles - b0) > 0), 32'(1));
        checkOutput("glitch_idle_after", 32'(is_receiving), 32'(0));
        checkOutput("glitch_no_received", 32'(recv_cycles - r0), 32'(0));
        checkOutput("glitch_no_error", 32'(err_cycles - e0), 32'(0));

        // Full duplex: send 0xA5 while receiving 0x3C.
        r0 = recv_cycles; e0 = err_cycles;
        @(negedge clk);
        tx_byte  = 8'hA5;
        transmit = 1'b1;
        fork
            applyStimulus(8'h3C, 1'b1);
            checkTxFrame("txA5", 8'hA5);
            begin
                repeat (4) @(negedge clk);
                transmit = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        #1;
        checkOutput("duplex_rx_byte", 32'(rx_byte), 32'(8'h3C));
        checkOutput("duplex_received_cycles", 32'(recv_cycles - r0), 32'(1));
        checkOutput("duplex_no_error", 32'(err_cycles - e0), 32'(0));

        // Reset in the middle of both frames.
        @(negedge clk);
        tx_byte  = 8'h00;
        transmit = 1'b1;
        rx       = 1'b0;
        repeat (2) @(negedge clk);
        transmit = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        checkOutput("midrst_tx_busy_before", 32'(is_transmitting), 32'(1));
        checkOutput("midrst_rx_busy_before", 32'(is_receiving), 32'(1));
        rx  = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_tx", 32'(tx), 32'(1));
        checkOutput("midrst_tx_busy", 32'(is_transmitting), 32'(0));
        checkOutput("midrst_rx_busy", 32'(is_receiving), 32'(0));
        checkOutput("midrst_rx_byte", 32'(rx_byte), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
